// File: rtl/cmd_pkg.sv
// Shared definitions for the command path: opcodes, framer state encoding
// and frame length. Frame length depends on CMD_CHKSUM_EN (checksum byte).
package cmd_pkg;

  localparam logic [7:0] SET_PTCH  = 8'h02;
  localparam logic [7:0] SET_ROLL  = 8'h03;
  localparam logic [7:0] SET_YAW   = 8'h04;
  localparam logic [7:0] SET_THRST = 8'h05;
  localparam logic [7:0] SET_CAL   = 8'h06;
  localparam logic [7:0] SET_EMGL  = 8'h07;
  localparam logic [7:0] SET_MOFF  = 8'h08;

`ifdef CMD_CHKSUM_EN
  typedef enum logic [1:0] {IDLE, HI, LO, CHK} frm_state_t;
  localparam int FRAME_BYTES = 4;
`else
  typedef enum logic [1:0] {IDLE, HI, LO} frm_state_t;
  localparam int FRAME_BYTES = 3;
`endif

  // Checksum carried in the optional 4th byte: ones' complement of the sum.
  function automatic logic [7:0] frame_chksum(input logic [7:0] c,
                                              input logic [7:0] h,
                                              input logic [7:0] l);
    frame_chksum = ~(c + h + l);
  endfunction

endpackage

// File: rtl/frame_timer.sv
// Inter-byte timeout counter. Counts while run=1, cleared by clr, and
// raises expired (combinational) in the cycle the count reaches
// TIMEOUT_CYCLES-1; the count restarts from 0 on that edge.
module frame_timer #(
  parameter int TIMEOUT_CYCLES = 2_500_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic run,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CYCLES);

  logic [CW-1:0] cnt_q, cnt_d;

  // Terminal count detection
  always_comb begin
    expired = run && (cnt_q == CW'(TIMEOUT_CYCLES - 1));
  end

  // Next count: clear on byte/idle/expiry, otherwise advance while running
  always_comb begin
    cnt_d = cnt_q;
    if (clr || expired || !run) cnt_d = '0;
    else                        cnt_d = cnt_q + CW'(1);
  end

  // Counter register
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/cmd_frame_rx.sv
// Byte-to-command framer: assembles cmd/hi/lo (plus checksum when
// CMD_CHKSUM_EN is defined) from UART bytes and holds the result for the
// consumer.
// Handshake: a byte is taken on every edge with rx_rdy=1 (clr_rx_rdy mirrors
// rx_rdy); cmd_rdy is a level held until the edge on which clr_cmd_rdy=1.
module cmd_frame_rx
  import cmd_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 2_500_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_rdy,
  input  logic [7:0]  rx_data,
  output logic        clr_rx_rdy,
  output logic [7:0]  cmd,
  output logic [15:0] data,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  output logic        frame_drop,
  output logic        chk_err
);

  frm_state_t  state_q, state_d;
  logic [7:0]  cmd_sh_q, cmd_sh_d;
  logic [7:0]  hi_sh_q, hi_sh_d;
  logic [7:0]  cmd_q, cmd_d;
  logic [15:0] data_q, data_d;
  logic        cmd_rdy_q, cmd_rdy_d;
  logic        drop_q, drop_d;
  logic        chk_err_q, chk_err_d;
  logic        expired;
  logic        done;
  logic        chk_ok;
  logic [7:0]  lo_byte;

`ifdef CMD_CHKSUM_EN
  logic [7:0]  lo_sh_q, lo_sh_d;
`endif

  assign clr_rx_rdy = rx_rdy;
  assign cmd        = cmd_q;
  assign data       = data_q;
  assign cmd_rdy    = cmd_rdy_q;
  assign frame_drop = drop_q;
  assign chk_err    = chk_err_q;

  frame_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clr     (rx_rdy),
    .run     (state_q != IDLE),
    .expired (expired)
  );

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cmd_sh_q  <= '0;
      hi_sh_q   <= '0;
      cmd_q     <= '0;
      data_q    <= '0;
      cmd_rdy_q <= 1'b0;
      drop_q    <= 1'b0;
      chk_err_q <= 1'b0;
`ifdef CMD_CHKSUM_EN
      lo_sh_q   <= '0;
`endif
    end else begin
      state_q   <= state_d;
      cmd_sh_q  <= cmd_sh_d;
      hi_sh_q   <= hi_sh_d;
      cmd_q     <= cmd_d;
      data_q    <= data_d;
      cmd_rdy_q <= cmd_rdy_d;
      drop_q    <= drop_d;
      chk_err_q <= chk_err_d;
`ifdef CMD_CHKSUM_EN
      lo_sh_q   <= lo_sh_d;
`endif
    end
  end

  // Next state: a timeout restarts the frame, and a byte on that same edge
  // is taken as a fresh cmd byte
  always_comb begin
    state_d = state_q;
    if (expired) begin
      state_d = rx_rdy ? HI : IDLE;
    end else if (rx_rdy) begin
      case (state_q)
        IDLE:    state_d = HI;
        HI:      state_d = LO;
`ifdef CMD_CHKSUM_EN
        LO:      state_d = CHK;
        CHK:     state_d = IDLE;
`else
        LO:      state_d = IDLE;
`endif
        default: state_d = IDLE;
      endcase
    end
  end

  // Shadow capture, frame completion, overrun and checksum handling
  always_comb begin
    cmd_sh_d  = cmd_sh_q;
    hi_sh_d   = hi_sh_q;
    cmd_d     = cmd_q;
    data_d    = data_q;
    cmd_rdy_d = cmd_rdy_q && !clr_cmd_rdy;
    drop_d    = expired;
    chk_err_d = 1'b0;
`ifdef CMD_CHKSUM_EN
    lo_sh_d   = lo_sh_q;
    lo_byte   = lo_sh_q;
    done      = rx_rdy && !expired && (state_q == CHK);
    chk_ok    = (rx_data == frame_chksum(cmd_sh_q, hi_sh_q, lo_sh_q));
    if (rx_rdy && !expired && state_q == LO) lo_sh_d = rx_data;
`else
    lo_byte   = rx_data;
    done      = rx_rdy && !expired && (state_q == LO);
    chk_ok    = 1'b1;
`endif
    if (rx_rdy && (expired || state_q == IDLE)) cmd_sh_d = rx_data;
    if (rx_rdy && !expired && state_q == HI)    hi_sh_d  = rx_data;
    if (done) begin
      if (!chk_ok) begin
        chk_err_d = 1'b1;
      end else if (cmd_rdy_q && !clr_cmd_rdy) begin
        drop_d = 1'b1;
      end else begin
        cmd_d     = cmd_sh_q;
        data_d    = {hi_sh_q, lo_byte};
        cmd_rdy_d = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cmd_frame_rx.sv
// Directed bench for cmd_frame_rx with TIMEOUT_CYCLES=16. Frames are sent
// with a checksum byte appended when CMD_CHKSUM_EN is defined.
module tb_cmd_frame_rx;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx_rdy;
  logic [7:0]  rx_data;
  logic        clr_rx_rdy;
  logic [7:0]  cmd;
  logic [15:0] data;
  logic        cmd_rdy;
  logic        clr_cmd_rdy;
  logic        frame_drop;
  logic        chk_err;

  int n_tests = 0;
  int n_fail  = 0;

  cmd_frame_rx #(.TIMEOUT_CYCLES(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .rx_rdy      (rx_rdy),
    .rx_data     (rx_data),
    .clr_rx_rdy  (clr_rx_rdy),
    .cmd         (cmd),
    .data        (data),
    .cmd_rdy     (cmd_rdy),
    .clr_cmd_rdy (clr_cmd_rdy),
    .frame_drop  (frame_drop),
    .chk_err     (chk_err)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send_byte(input logic [7:0] b, input logic clr_on_edge);
    rx_rdy      = 1'b1;
    rx_data     = b;
    clr_cmd_rdy = clr_on_edge;
    #1 check("clr_rx_rdy", 32'(clr_rx_rdy), 32'd1);
    @(posedge clk);
    @(negedge clk);
    rx_rdy      = 1'b0;
    clr_cmd_rdy = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] c, input logic [7:0] h,
                            input logic [7:0] l, input logic clr_last);
    logic [7:0] cs;
    cs = ~(c + h + l);
    send_byte(c, 1'b0);
    send_byte(h, 1'b0);
`ifdef CMD_CHKSUM_EN
    send_byte(l, 1'b0);
    send_byte(cs, clr_last);
`else
    send_byte(l, clr_last);
    if (cs == 8'h00) check("unused_cs", 32'(cs), 32'd0);
`endif
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic ack;
    clr_cmd_rdy = 1'b1;
    @(negedge clk);
    clr_cmd_rdy = 1'b0;
  endtask

  initial begin
    rst = 1'b1; rx_rdy = 1'b0; rx_data = 8'h00; clr_cmd_rdy = 1'b0;
    idle(3);
    rst = 1'b0;
    idle(1);
    check("rst_cmd", 32'(cmd), 32'h00);
    check("rst_data", 32'(data), 32'h0000);
    check("rst_cmd_rdy", 32'(cmd_rdy), 32'd0);
    check("rst_drop", 32'(frame_drop), 32'd0);
    check("rst_chk_err", 32'(chk_err), 32'd0);

    // Basic frame
    send_frame(8'h02, 8'h12, 8'h34, 1'b0);
    check("f1_cmd_rdy", 32'(cmd_rdy), 32'd1);
    check("f1_cmd", 32'(cmd), 32'h02);
    check("f1_data", 32'(data), 32'h1234);
    check("f1_drop", 32'(frame_drop), 32'd0);

    // Acknowledge
    ack();
    check("ack_cmd_rdy", 32'(cmd_rdy), 32'd0);
    check("ack_cmd", 32'(cmd), 32'h02);
    check("ack_data", 32'(data), 32'h1234);

    // Overrun: hold a frame, then send another without clearing
    send_frame(8'h02, 8'h12, 8'h34, 1'b0);
    send_frame(8'h05, 8'h00, 8'hFF, 1'b0);
    check("ovr_drop", 32'(frame_drop), 32'd1);
    check("ovr_cmd", 32'(cmd), 32'h02);
    check("ovr_data", 32'(data), 32'h1234);
    check("ovr_cmd_rdy", 32'(cmd_rdy), 32'd1);
    idle(1);
    check("ovr_drop_pulse", 32'(frame_drop), 32'd0);
    ack();
    send_frame(8'h05, 8'h00, 8'hFF, 1'b0);
    check("resend_cmd", 32'(cmd), 32'h05);
    check("resend_data", 32'(data), 32'h00FF);
    check("resend_drop", 32'(frame_drop), 32'd0);
    ack();

    // Timeout after a partial frame
    send_byte(8'h03, 1'b0);
    send_byte(8'hAB, 1'b0);
    idle(15);
    check("to_early_drop", 32'(frame_drop), 32'd0);
    idle(1);
    check("to_drop", 32'(frame_drop), 32'd1);
    check("to_cmd_rdy", 32'(cmd_rdy), 32'd0);
    idle(1);
    check("to_drop_pulse", 32'(frame_drop), 32'd0);
    send_frame(8'h04, 8'h00, 8'h10, 1'b0);
    check("after_to_cmd", 32'(cmd), 32'h04);
    check("after_to_data", 32'(data), 32'h0010);
    check("after_to_rdy", 32'(cmd_rdy), 32'd1);

    // Ack coincides with completion: new frame loads, no overrun
    send_frame(8'h07, 8'h00, 8'h00, 1'b1);
    check("sim_cmd_rdy", 32'(cmd_rdy), 32'd1);
    check("sim_cmd", 32'(cmd), 32'h07);
    check("sim_drop", 32'(frame_drop), 32'd0);

    // Reset mid-frame
    send_byte(8'h06, 1'b0);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    check("mrst_cmd", 32'(cmd), 32'h00);
    check("mrst_data", 32'(data), 32'h0000);
    check("mrst_cmd_rdy", 32'(cmd_rdy), 32'd0);
    send_frame(8'h08, 8'h00, 8'h00, 1'b0);
    check("mrst_new_cmd", 32'(cmd), 32'h08);
    check("mrst_new_rdy", 32'(cmd_rdy), 32'd1);
    ack();

`ifdef CMD_CHKSUM_EN
    send_byte(8'h02, 1'b0); send_byte(8'h12, 1'b0);
    send_byte(8'h34, 1'b0); send_byte(8'hB7, 1'b0);
    check("cs_ok_rdy", 32'(cmd_rdy), 32'd1);
    check("cs_ok_data", 32'(data), 32'h1234);
    check("cs_ok_err", 32'(chk_err), 32'd0);
    ack();
    send_byte(8'h02, 1'b0); send_byte(8'h12, 1'b0);
    send_byte(8'h34, 1'b0); send_byte(8'hB6, 1'b0);
    check("cs_bad_err", 32'(chk_err), 32'd1);
    check("cs_bad_rdy", 32'(cmd_rdy), 32'd0);
    check("cs_bad_drop", 32'(frame_drop), 32'd0);
    idle(1);
    check("cs_err_pulse", 32'(chk_err), 32'd0);
`else
    check("no_cs_err", 32'(chk_err), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
